// File: rtl/crossbar_rotate.sv
// crossbar_rotate: registers an N-lane vector rotated by a lane offset that
// advances by STEP on every capture and wraps after PHASES captures.
// Optional feature macro: CROSSBAR_ROTATE_DIR_EN. When it is defined, io_dir
// selects rotate-down. When it is undefined, io_dir is ignored and only the
// rotate-up mux is built.
// Handshake: a capture happens on a clock edge where io_clk_en & io_start is
// high. Its result appears on io_out one cycle later, qualified by a one-cycle
// io_out_valid strobe. There is no ready input, so the consumer must take
// io_out in the valid cycle.
module crossbar_rotate #(
  parameter int N      = 16,
  parameter int W      = 32,
  parameter int STEP   = 2,
  parameter int PHASES = 4,
  localparam int PW    = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           io_clk_en,
  input  logic           io_start,
  input  logic           io_dir,
  input  logic           io_phase_clr,
  input  logic [N*W-1:0] io_in,
  output logic [N*W-1:0] io_out,
  output logic           io_out_valid,
  output logic           io_wrap,
  output logic [PW-1:0]  io_phase,
  output logic           io_start_next_stage
);

  localparam int SW = $clog2(N);

  logic [N*W-1:0] out_q;
  logic [PW-1:0]  phase_q;
  logic           valid_q;
  logic           wrap_q;
  logic           sns_q;

  logic [PW-1:0]  ep;
  logic           last;
  logic [63:0]    prod;
  logic [SW-1:0]  sh;
  logic [SW-1:0]  idx;
  logic [W-1:0]   in_lane [N];
  logic [N*W-1:0] rot_d;

`ifndef CROSSBAR_ROTATE_DIR_EN
  logic unused_dir;
  assign unused_dir = io_dir;
`endif

  // Effective phase, lane shift and the rotated vector for this cycle.
  // The phase*STEP product is kept at full width before the mod N reduction.
  always_comb begin
    ep    = io_phase_clr ? '0 : phase_q;
    last  = (ep == PW'(PHASES - 1));
    prod  = 64'(ep) * 64'(STEP);
    sh    = SW'(prod % 64'(N));
    idx   = '0;
    rot_d = '0;
    for (int k = 0; k < N; k++) begin
      in_lane[k] = io_in[k*W +: W];
    end
    for (int i = 0; i < N; i++) begin
`ifdef CROSSBAR_ROTATE_DIR_EN
      if (io_dir) begin
        idx = SW'((32'(i) + 32'(N) - 32'(sh)) % 32'(N));
      end else begin
        idx = SW'((32'(i) + 32'(sh)) % 32'(N));
      end
`else
      idx = SW'((32'(i) + 32'(sh)) % 32'(N));
`endif
      rot_d[i*W +: W] = in_lane[idx];
    end
  end

  // Capture, phase advance and strobes; io_clk_en low freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      sns_q   <= 1'b0;
    end else if (io_clk_en) begin
      if (io_start) begin
        out_q   <= rot_d;
        phase_q <= last ? '0 : ep + PW'(1);
        valid_q <= 1'b1;
        wrap_q  <= last;
        sns_q   <= 1'b1;
      end else begin
        valid_q <= 1'b0;
        wrap_q  <= 1'b0;
        if (io_phase_clr) begin
          phase_q <= '0;
        end
      end
    end
  end

  assign io_out              = out_q;
  assign io_out_valid        = valid_q;
  assign io_wrap             = wrap_q;
  assign io_phase            = phase_q;
  assign io_start_next_stage = sns_q;

endmodule

// File: tb/tb_crossbar_rotate.sv
// Bench for crossbar_rotate (N=16, W=32, STEP=2, PHASES=4): a lane-array
// model of the rotate rules is compared every falling edge, plus directed
// literal expectations taken from hand-worked captures.
module tb_crossbar_rotate;
  localparam int N = 16;
  localparam int W = 32;
  localparam int STEP = 2;
  localparam int PHASES = 4;
  localparam int PW = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           io_clk_en = 1'b0;
  logic           io_start = 1'b0;
  logic           io_dir = 1'b0;
  logic           io_phase_clr = 1'b0;
  logic [N*W-1:0] io_in;
  logic [N*W-1:0] io_out;
  logic           io_out_valid;
  logic           io_wrap;
  logic [PW-1:0]  io_phase;
  logic           io_start_next_stage;

  logic [W-1:0] in_v [N];
  int n_checks = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) io_in[k*W +: W] = in_v[k];
  end

  crossbar_rotate #(.N(N), .W(W), .STEP(STEP), .PHASES(PHASES)) dut (
    .clk(clk), .reset_n(reset_n), .io_clk_en(io_clk_en), .io_start(io_start),
    .io_dir(io_dir), .io_phase_clr(io_phase_clr), .io_in(io_in),
    .io_out(io_out), .io_out_valid(io_out_valid), .io_wrap(io_wrap),
    .io_phase(io_phase), .io_start_next_stage(io_start_next_stage)
  );

  // behavioural model: lane array plus phase index
  logic [W-1:0] m_out [N];
  int m_phase;
  bit m_valid, m_wrap, m_sns;

  always @(posedge clk or negedge reset_n) begin : model
    int ep, sh, src;
    bit down;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_out[i] = '0;
      m_phase = 0; m_valid = 0; m_wrap = 0; m_sns = 0;
    end else if (io_clk_en) begin
      ep = io_phase_clr ? 0 : m_phase;
`ifdef CROSSBAR_ROTATE_DIR_EN
      down = io_dir;
`else
      down = 1'b0;
`endif
      if (io_start) begin
        sh = (ep * STEP) % N;
        for (int i = 0; i < N; i++) begin
          src = down ? (i - sh + N) % N : (i + sh) % N;
          m_out[i] = in_v[src];
        end
        m_wrap  = (ep == PHASES - 1);
        m_phase = (ep + 1) % PHASES;
        m_valid = 1;
        m_sns   = 1;
      end else begin
        m_valid = 0;
        m_wrap  = 0;
        m_phase = ep;
      end
    end
  end

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return io_out[i*W +: W];
  endfunction

  // scoreboard compare process: every falling edge
  always @(negedge clk) begin : compare
    logic [N*W-1:0] mv;
    for (int i = 0; i < N; i++) mv[i*W +: W] = m_out[i];
    chk("model_out", io_out, mv);
    chk("model_valid", {{(N*W-1){1'b0}}, io_out_valid}, {{(N*W-1){1'b0}}, m_valid});
    chk("model_wrap", {{(N*W-1){1'b0}}, io_wrap}, {{(N*W-1){1'b0}}, m_wrap});
    chk("model_phase", {{(N*W-PW){1'b0}}, io_phase}, (N*W)'(m_phase));
    chk("model_sns", {{(N*W-1){1'b0}}, io_start_next_stage}, {{(N*W-1){1'b0}}, m_sns});
  end

  // driver task: apply one cycle of controls, return just after the edge
  task automatic cyc(input bit en, input bit st, input bit dr, input bit cl);
    io_clk_en = en; io_start = st; io_dir = dr; io_phase_clr = cl;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    chk(name, (N*W)'(act), (N*W)'(exp));
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    int e0, e1, e2;
    logic [3:0] ctl [10];
    for (int k = 0; k < N; k++) in_v[k] = W'(k);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", io_out, '0);
    lit("reset_phase", int'(io_phase), 0);
    lit("reset_valid", int'(io_out_valid), 0);
    lit("reset_wrap", int'(io_wrap), 0);
    lit("reset_sns", int'(io_start_next_stage), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // five back-to-back captures, rotate-up
    cyc(1, 1, 0, 0);
    lit("c1_lane0", int'(lane(0)), 0);
    lit("c1_lane15", int'(lane(15)), 15);
    lit("c1_phase", int'(io_phase), 1);
    lit("c1_wrap", int'(io_wrap), 0);
    lit("c1_valid", int'(io_out_valid), 1);
    lit("c1_sns", int'(io_start_next_stage), 1);
    cyc(1, 1, 0, 0);
    lit("c2_lane0", int'(lane(0)), 2);
    lit("c2_lane15", int'(lane(15)), 1);
    lit("c2_phase", int'(io_phase), 2);
    lit("c2_wrap", int'(io_wrap), 0);
    lit("c2_valid", int'(io_out_valid), 1);
    cyc(1, 1, 0, 0);
    lit("c3_lane12", int'(lane(12)), 0);
    lit("c3_phase", int'(io_phase), 3);
    lit("c3_wrap", int'(io_wrap), 0);
    lit("c3_valid", int'(io_out_valid), 1);
    cyc(1, 1, 0, 0);
    lit("c4_lane10", int'(lane(10)), 0);
    lit("c4_lane15", int'(lane(15)), 5);
    lit("c4_phase", int'(io_phase), 0);
    lit("c4_wrap", int'(io_wrap), 1);
    lit("c4_valid", int'(io_out_valid), 1);
    cyc(1, 1, 0, 0);
    lit("c5_lane7", int'(lane(7)), 7);
    lit("c5_phase", int'(io_phase), 1);
    lit("c5_wrap", int'(io_wrap), 0);
    lit("c5_valid", int'(io_out_valid), 1);
    lit("c5_sns", int'(io_start_next_stage), 1);

    // rotate-down at phase 1
`ifdef CROSSBAR_ROTATE_DIR_EN
    e0 = 14; e1 = 15; e2 = 0;
`else
    e0 = 2; e1 = 3; e2 = 4;
`endif
    cyc(1, 1, 1, 0);
    lit("dn_lane0", int'(lane(0)), e0);
    lit("dn_lane1", int'(lane(1)), e1);
    lit("dn_lane2", int'(lane(2)), e2);
    lit("dn_phase", int'(io_phase), 2);

    // clock enable low freezes state even with io_start high
    for (int r = 0; r < 3; r++) begin
      cyc(0, 1, 0, 1);
      lit("frz_lane0", int'(lane(0)), e0);
      lit("frz_phase", int'(io_phase), 2);
      lit("frz_valid", int'(io_out_valid), 1);
      lit("frz_wrap", int'(io_wrap), 0);
    end

    // phase clear with capture at phase 2
    cyc(1, 1, 0, 1);
    lit("clrcap_lane5", int'(lane(5)), 5);
    lit("clrcap_lane0", int'(lane(0)), 0);
    lit("clrcap_phase", int'(io_phase), 1);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    lit("pre_clr_phase", int'(io_phase), 3);
    cyc(1, 0, 0, 1);
    lit("clr_phase", int'(io_phase), 0);
    lit("clr_valid", int'(io_out_valid), 0);
    lit("clr_wrap", int'(io_wrap), 0);
    lit("clr_lane0", int'(lane(0)), 4);

    // asynchronous reset between edges at phase 2
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    lit("prerst_phase", int'(io_phase), 2);
    io_clk_en = 0; io_start = 0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", io_out, '0);
    lit("arst_phase", int'(io_phase), 0);
    lit("arst_sns", int'(io_start_next_stage), 0);
    lit("arst_valid", int'(io_out_valid), 0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 1, 0, 0);
    lit("postrst_lane9", int'(lane(9)), 9);
    lit("postrst_phase", int'(io_phase), 1);
    lit("postrst_sns", int'(io_start_next_stage), 1);

    // directed control table with distinct lane data, checked by the model
    for (int k = 0; k < N; k++) in_v[k] = 32'hA500_0000 + W'(k * 7);
    ctl = '{4'b1100, 4'b1110, 4'b1101, 4'b0100, 4'b1111,
            4'b1000, 4'b1100, 4'b1110, 4'b1001, 4'b1110};
    for (int t = 0; t < 10; t++) cyc(ctl[t][3], ctl[t][2], ctl[t][1], ctl[t][0]);
    cyc(0, 0, 0, 0);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/crossbar_rotate.md
# crossbar_rotate

Parametrised rotating crossbar for the convolution datapath: on each qualified start cycle it registers an N-lane input vector rotated by a phase-dependent lane offset. The offset advances by a fixed step per capture and wraps after a configurable number of phases. The block sits between the line-buffer stage and the PE array. It generalises the fixed 16-lane, 4-phase shift-up crossbar with parametrised geometry, continuous phase wrap, selectable rotation direction, phase clear and per-capture valid/wrap strobes.

## Interface
- N, default 16: lane count, at least 2.
- W, default 32: lane data width.
- STEP, default 2: lane offset added per phase; may exceed N and is reduced mod N.
- PHASES, default 4: phases per cycle, at least 1. Phase counter width PW = max(1, clog2(PHASES)).
- clk  input  1  single clock, rising edge.
- reset_n  input  1  reset: asynchronous assert, active-low.
- io_clk_en  input  1  stage clock enable.
- io_start  input  1  capture request.
- io_dir  input  1  0 selects rotate-up, 1 selects rotate-down; sampled on the capture cycle.
- io_phase_clr  input  1  synchronous phase restart.
- io_in  input  N*W  input lanes; lane k occupies bits [k*W +: W].
- io_out  output  N*W  registered rotated lanes, same packing as io_in.
- io_out_valid  output  1  one-cycle strobe following each capture.
- io_wrap  output  1  one-cycle strobe following a capture at phase PHASES-1.
- io_phase  output  PW  current phase counter value.
- io_start_next_stage  output  1  sticky flag; set by the first capture.

## Operation
- Capture condition: cap = io_clk_en & io_start.
- Effective phase: ep = 0 if io_phase_clr, else phase.
- Shift: sh = (ep*STEP) mod N. The multiply runs at full width, with no truncation before the mod.
- Rotate-up: out[i] = in[(i+sh) mod N].
- Rotate-down: out[i] = in[(i-sh+N) mod N].
- On cap:
  - io_out is loaded with the rotated vector.
  - phase becomes (ep==PHASES-1) ? 0 : ep+1.
  - io_out_valid is set to 1.
  - io_wrap is set to (ep==PHASES-1).
  - io_start_next_stage is set to 1.
- On no cap:
  - io_out holds its value.
  - io_out_valid and io_wrap are set to 0.
  - phase becomes 0 if io_phase_clr, otherwise it holds.
- io_phase_clr with cap: the capture uses phase 0 and the counter advances to 1. If PHASES=1 the counter stays at 0 and io_wrap fires.
- PHASES=1: every capture uses sh=0, i.e. a pass-through register, and io_wrap fires on every capture.
- io_start_next_stage clears only on reset.
- io_clk_en low freezes all state; io_start alone has no effect.

## Timing
- Reset, asynchronous and active-low: io_out=0 on all lanes, phase=0, io_out_valid=0, io_wrap=0, io_start_next_stage=0.
- Reset asserted mid-sequence clears all state immediately. The first capture after release uses phase 0.
- Latency: io_out, io_out_valid, io_wrap, io_phase and io_start_next_stage update at the clock edge where cap is sampled high. They are visible in the next cycle.
- Back-to-back captures are supported. io_out_valid stays high continuously and the phases advance every cycle.
- No backpressure: the consumer must accept io_out in the valid cycle.
- Combinational path: io_in to io_out register only. No input-to-output combinational path exists.

## Configuration
- CROSSBAR_ROTATE_DIR_EN defined: io_dir is honoured and rotate-down is available.
- CROSSBAR_ROTATE_DIR_EN undefined: io_dir stays on the port list but is ignored. Rotation is always up and the down-rotate mux is not built.

## Test plan
All scenarios use N=16, W=32, STEP=2, PHASES=4 and in[k]=k, with the macro defined unless stated.
- Reset then four captures with io_dir=0:
  - capture 1: out[i]=i;
  - capture 2: out[0]=2, out[15]=1;
  - capture 3: out[12]=0;
  - capture 4: out[10]=0, out[15]=5;
  - io_wrap high only in the cycle after capture 4;
  - io_phase reads 1,2,3,0.
- Fifth capture: out[i]=i again. io_start_next_stage stays 1 throughout. io_out_valid stays high across all five back-to-back cycles.
- io_dir=1 at phase 1: out[0]=14, out[1]=15, out[2]=0.
- With the macro undefined, the same stimulus gives out[0]=2.
- io_start=1 with io_clk_en=0 for 3 cycles: io_out, io_phase and the strobes are unchanged.
- io_phase_clr with cap at phase 2: out[i]=i and io_phase=1 next cycle. io_phase_clr alone at phase 3 gives io_phase=0 and no valid strobe.
- reset_n pulsed low between clock edges at phase 2: io_out=0, io_phase=0 and io_start_next_stage=0 with no clock edge. The next capture gives out[i]=i.
